vga_vram_ctrl: RTL and testbench
================================

// Module: vga_vram_ctrl
// PURPOSE
//  SRAM-side VRAM controller feeding the VGA pixel buffer's vram_* read port (core clock domain).
//  Arbitrates display reads (priority) against single-byte host writes to an external 16-bit async SRAM.
//  8-bit pixels live two per SRAM word; includes an anti-starvation timer for host writes.
// PARAMETERS
//  AWIDTH   19  byte (pixel) address width; SRAM word address = addr[AWIDTH-1:1]
//  PWIDTH   8   pixel width; fixed at 8 (SRAM word = 2*PWIDTH)
//  LATENCY  2   cycles from read accept to vram_vld; must be >= 2
//  MAX_WAIT 16  max IDLE cycles a buffered host write waits before forcing vram_busy
// PORTS
//  clk_core    in   1         core clock; the only clock
//  rst_core    in   1         asynchronous, active-low reset
//  vram_rd     in   1         display read request; accepted when vram_rd && !vram_busy
//  vram_addr   in   AWIDTH    display read pixel address
//  vram_busy   out  1         read port stalled; request not accepted this cycle
//  vram_data   out  PWIDTH    read pixel, valid with vram_vld
//  vram_vld    out  1         one-cycle pulse per accepted read, in order
//  host_wr     in   1         host write request; accepted when host_wr && host_ready
//  host_addr   in   AWIDTH    host write pixel address
//  host_wdata  in   PWIDTH    host write pixel
//  host_ready  out  1         single-entry write buffer empty
//  sram_addr   out  AWIDTH-1  SRAM word address (registered)
//  sram_dq_o   out  2*PWIDTH  SRAM write data (registered)
//  sram_dq_oe  out  1         tristate enable for sram_dq_o (registered)
//  sram_dq_i   in   2*PWIDTH  SRAM read data
//  sram_ce_n / sram_oe_n / sram_we_n / sram_ub_n / sram_lb_n  out 1 each  SRAM strobes, active-low, registered
// BEHAVIOUR
//  Reset: state IDLE, buffer empty, wait_cnt 0; vram_busy 0, vram_vld 0, vram_data 0, host_ready 1,
//   all sram_*_n 1, sram_dq_oe 0, sram_addr 0, sram_dq_o 0. Reset mid-operation aborts writes and drops in-flight reads.
//  All SRAM outputs are registered: a decision in cycle N drives the pins in cycle N+1.
//  host_ready = !wbuf_valid. Accept loads {addr,data}, sets wbuf_valid; it clears on entry to WR_SETUP.
//  vram_busy = (state != IDLE) | (wbuf_valid & wait_cnt == MAX_WAIT). Combinational from registers only.
//  FSM: IDLE, WR_SETUP, WR_PULSE, WR_HOLD.
//   IDLE: read accepted -> next cycle ce_n=0, oe_n=0, ub_n=lb_n=0, dq_oe=0, sram_addr=vram_addr[AWIDTH-1:1].
//    no read and wbuf_valid -> WR_SETUP. forced (wait_cnt==MAX_WAIT) -> WR_SETUP even if vram_rd high.
//    otherwise pins idle (ce_n=oe_n=we_n=1, dq_oe=0). Reads may be accepted every cycle back-to-back.
//   WR_SETUP: ce_n=0, oe_n=1, we_n=1, dq_oe=0 (bus turnaround), sram_addr=buf_addr[AWIDTH-1:1].
//   WR_PULSE: we_n=0, dq_oe=1, dq_o={wdata,wdata}; buf_addr[0]=1 -> ub_n=0,lb_n=1; else ub_n=1,lb_n=0.
//   WR_HOLD: we_n=1, dq_oe=1, data/addr held -> IDLE. Write occupancy = 3 cycles of vram_busy.
//  wait_cnt: increments (saturating at MAX_WAIT) each IDLE cycle with wbuf_valid and no write start;
//   clears on entry to WR_SETUP. Width $clog2(MAX_WAIT+1).
//  Read datapath: sram_dq_i sampled at end of pin cycle (accept+1) with stored addr[0];
//   addr[0]=1 selects [15:8], else [7:0]. Further LATENCY-2 register stages; vram_vld/vram_data appear
//   exactly LATENCY cycles after the accept cycle. vram_data holds its last value when vram_vld=0.
//  Simultaneous host_wr accept and write start: impossible (host_ready=0 while buffer full). Host may refill
//   the buffer during WR_PULSE/WR_HOLD; that write then waits in IDLE like any other.
//  vram_rd asserted while vram_busy: ignored, no vld generated; requester holds it.
// TESTING
//  Reset: assert rst_core low mid-WR_PULSE -> immediately we_n=1, dq_oe=0, busy=0, host_ready=1, vld=0.
//  Read: SRAM word 2 = 0xA55A, vram_rd with addr 0x00005 at cycle N -> ce_n/oe_n low at N+1, sram_addr=2,
//   vram_vld at N+2 with vram_data=0xA5; addr 0x00004 -> 0x5A.
//  Stream: vram_rd high 8 cycles, addr 0..7 -> 8 vld pulses, back-to-back, in order, LATENCY=2 after each.
//  Idle write: host_wr addr 0x00003 data 0x3C, vram_rd low -> WR_SETUP/PULSE/HOLD, ub_n=0, lb_n=1,
//   dq_o=0x3C3C during pulse, sram_addr=1; readback of 0x00003 returns 0x3C, 0x00002 unchanged.
//  Starvation: vram_rd held high, host write accepted -> 16 IDLE wait cycles, vram_busy high 1+3 cycles,
//   write completes, reads resume; no vld lost or duplicated.
//  Refill: second host_wr during WR_HOLD -> accepted, host_ready low, written after next read gap or MAX_WAIT.

Source files
------------

// File: rtl/vga_vram_ctrl_if.sv
// Bus bundle between the VGA pixel buffer / host and the VRAM controller,
// including the external SRAM pin group.
interface vga_vram_ctrl_if #(
  parameter int AWIDTH = 19,
  parameter int PWIDTH = 8
);
  // Handshakes: a display read transfers in any cycle where vram_rd && !vram_busy
  // (requester holds vram_rd and vram_addr until then); a host write transfers when
  // host_wr && host_ready. vram_vld pulses once per transferred read, in order.
  logic                  vram_rd;
  logic [AWIDTH-1:0]     vram_addr;
  logic                  vram_busy;
  logic [PWIDTH-1:0]     vram_data;
  logic                  vram_vld;

  logic                  host_wr;
  logic [AWIDTH-1:0]     host_addr;
  logic [PWIDTH-1:0]     host_wdata;
  logic                  host_ready;

  logic [AWIDTH-2:0]     sram_addr;
  logic [2*PWIDTH-1:0]   sram_dq_o;
  logic                  sram_dq_oe;
  logic [2*PWIDTH-1:0]   sram_dq_i;
  logic                  sram_ce_n;
  logic                  sram_oe_n;
  logic                  sram_we_n;
  logic                  sram_ub_n;
  logic                  sram_lb_n;

  modport slave (
    input  vram_rd, vram_addr, host_wr, host_addr, host_wdata, sram_dq_i,
    output vram_busy, vram_data, vram_vld, host_ready,
    output sram_addr, sram_dq_o, sram_dq_oe,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );

  modport master (
    output vram_rd, vram_addr, host_wr, host_addr, host_wdata, sram_dq_i,
    input  vram_busy, vram_data, vram_vld, host_ready,
    input  sram_addr, sram_dq_o, sram_dq_oe,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n
  );
endinterface

// File: rtl/vga_vram_ctrl.sv
// VRAM controller: display reads (priority) and buffered single-pixel host writes
// sharing one 16-bit async SRAM, two 8-bit pixels per word.
module vga_vram_ctrl #(
  parameter int AWIDTH   = 19,
  parameter int PWIDTH   = 8,
  parameter int LATENCY  = 2,
  parameter int MAX_WAIT = 16
) (
  input  logic               clk_core,
  input  logic               rst_core,
  vga_vram_ctrl_if.slave     bus,
  output logic [1:0]         dbg_state
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {IDLE, WR_SETUP, WR_PULSE, WR_HOLD} state_t;

  state_t             state, state_nx;
  logic               wbuf_valid;
  logic [AWIDTH-1:0]  buf_addr;
  logic [PWIDTH-1:0]  buf_data;
  logic [CW-1:0]      wait_cnt;
  logic               forced, rd_accept, host_accept, wr_start;
  logic               wr_hi;
  logic               rd_pend, rd_hi;
  logic [LATENCY-2:0] vld_pipe;
  logic [PWIDTH-1:0]  data_pipe [LATENCY-1];

  assign forced          = wbuf_valid && (wait_cnt == CW'(MAX_WAIT));
  assign bus.vram_busy   = (state != IDLE) || forced;
  assign bus.host_ready  = !wbuf_valid;
  assign rd_accept       = bus.vram_rd && !bus.vram_busy;
  assign host_accept     = bus.host_wr && !wbuf_valid;
  assign dbg_state       = state;

  always_ff @(posedge clk_core or negedge rst_core) begin
    if (!rst_core) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    wr_start = 1'b0;
    case (state)
      IDLE: begin
        if (wbuf_valid && (!bus.vram_rd || forced)) begin
          wr_start = 1'b1;
          state_nx = WR_SETUP;
        end
      end
      WR_SETUP: state_nx = WR_PULSE;
      WR_PULSE: state_nx = WR_HOLD;
      WR_HOLD:  state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_core or negedge rst_core) begin
    if (!rst_core) begin
      wbuf_valid <= 1'b0;
      buf_addr   <= '0;
      buf_data   <= '0;
      wait_cnt   <= '0;
    end else begin
      if (wr_start) begin
        wbuf_valid <= 1'b0;
        wait_cnt   <= '0;
      end else begin
        if (host_accept) begin
          wbuf_valid <= 1'b1;
          buf_addr   <= bus.host_addr;
          buf_data   <= bus.host_wdata;
        end
        if (state == IDLE && wbuf_valid && wait_cnt != CW'(MAX_WAIT))
          wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  // Address, data and byte lane are captured at write start so a host refill
  // landing during WR_SETUP cannot disturb the write already on the pins.
  always_ff @(posedge clk_core or negedge rst_core) begin
    if (!rst_core) begin
      bus.sram_ce_n  <= 1'b1;
      bus.sram_oe_n  <= 1'b1;
      bus.sram_we_n  <= 1'b1;
      bus.sram_ub_n  <= 1'b1;
      bus.sram_lb_n  <= 1'b1;
      bus.sram_dq_oe <= 1'b0;
      bus.sram_addr  <= '0;
      bus.sram_dq_o  <= '0;
      wr_hi          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.sram_we_n  <= 1'b1;
          bus.sram_dq_oe <= 1'b0;
          if (wr_start) begin
            bus.sram_ce_n <= 1'b0;
            bus.sram_oe_n <= 1'b1;
            bus.sram_ub_n <= 1'b1;
            bus.sram_lb_n <= 1'b1;
            bus.sram_addr <= buf_addr[AWIDTH-1:1];
            bus.sram_dq_o <= {buf_data, buf_data};
            wr_hi         <= buf_addr[0];
          end else if (rd_accept) begin
            bus.sram_ce_n <= 1'b0;
            bus.sram_oe_n <= 1'b0;
            bus.sram_ub_n <= 1'b0;
            bus.sram_lb_n <= 1'b0;
            bus.sram_addr <= bus.vram_addr[AWIDTH-1:1];
          end else begin
            bus.sram_ce_n <= 1'b1;
            bus.sram_oe_n <= 1'b1;
            bus.sram_ub_n <= 1'b1;
            bus.sram_lb_n <= 1'b1;
          end
        end
        WR_SETUP: begin
          bus.sram_we_n  <= 1'b0;
          bus.sram_dq_oe <= 1'b1;
          bus.sram_ub_n  <= !wr_hi;
          bus.sram_lb_n  <= wr_hi;
        end
        WR_PULSE: begin
          bus.sram_we_n  <= 1'b1;
          bus.sram_dq_oe <= 1'b1;
        end
        default: begin
          bus.sram_ce_n  <= 1'b1;
          bus.sram_oe_n  <= 1'b1;
          bus.sram_we_n  <= 1'b1;
          bus.sram_ub_n  <= 1'b1;
          bus.sram_lb_n  <= 1'b1;
          bus.sram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

  // Read data is captured at the end of the pin cycle; later stages only move
  // data along with a valid so the output holds its last pixel between pulses.
  always_ff @(posedge clk_core or negedge rst_core) begin
    if (!rst_core) begin
      rd_pend  <= 1'b0;
      rd_hi    <= 1'b0;
      vld_pipe <= '0;
      for (int k = 0; k < LATENCY - 1; k++) data_pipe[k] <= '0;
    end else begin
      rd_pend <= rd_accept;
      if (rd_accept) rd_hi <= bus.vram_addr[0];
      vld_pipe[0] <= rd_pend;
      if (rd_pend)
        data_pipe[0] <= rd_hi ? bus.sram_dq_i[2*PWIDTH-1:PWIDTH] : bus.sram_dq_i[PWIDTH-1:0];
      for (int k = 1; k < LATENCY - 1; k++) begin
        vld_pipe[k] <= vld_pipe[k-1];
        if (vld_pipe[k-1]) data_pipe[k] <= data_pipe[k-1];
      end
    end
  end

  assign bus.vram_vld  = vld_pipe[LATENCY-2];
  assign bus.vram_data = data_pipe[LATENCY-2];
endmodule

// File: tb/tb_vga_vram_ctrl.sv
// Bench for vga_vram_ctrl with a behavioural async SRAM and a pixel reference array.
module tb_vga_vram_ctrl;
  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         checks;
  int         errors;
  int         cyc;

  logic [15:0] mem    [0:255];
  logic [7:0]  ref_px [0:511];

  vga_vram_ctrl_if #(.AWIDTH(19), .PWIDTH(8)) bus ();

  vga_vram_ctrl dut (
    .clk_core  (clk),
    .rst_core  (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // async SRAM: read when selected and not driven by controller; write while we_n low
  assign bus.sram_dq_i = (!bus.sram_ce_n && !bus.sram_oe_n && !bus.sram_dq_oe)
                         ? mem[bus.sram_addr[7:0]] : 16'hDEAD;

  always @(negedge clk) begin
    if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe) begin
      if (!bus.sram_ub_n) mem[bus.sram_addr[7:0]][15:8] = bus.sram_dq_o[15:8];
      if (!bus.sram_lb_n) mem[bus.sram_addr[7:0]][7:0]  = bus.sram_dq_o[7:0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (bus.vram_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", bus.vram_busy); end
    checks++; if (bus.vram_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %0b exp 0", bus.vram_vld); end
    checks++; if (bus.vram_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", bus.vram_data); end
    checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL reset_host_ready got %0b exp 1", bus.host_ready); end
    checks++; if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n} !== 5'b11111) begin
      errors++; $display("FAIL reset_strobes got %b exp 11111",
        {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_ub_n, bus.sram_lb_n}); end
    checks++; if (bus.sram_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_dq_oe got %0b exp 0", bus.sram_dq_oe); end
    checks++; if (bus.sram_addr !== 18'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", bus.sram_addr); end
    checks++; if (bus.sram_dq_o !== 16'h0000) begin errors++; $display("FAIL reset_dq_o got %h exp 0000", bus.sram_dq_o); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", dbg_state); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_read(input logic [18:0] addr, input logic [7:0] exp_px);
    tick();
    bus.vram_rd = 1'b1; bus.vram_addr = addr;
    tick();
    bus.vram_rd = 1'b0;
    checks++; if (bus.sram_ce_n !== 1'b0 || bus.sram_oe_n !== 1'b0 || bus.sram_we_n !== 1'b1) begin
      errors++; $display("FAIL read_strobes got ce%0b oe%0b we%0b exp ce0 oe0 we1", bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n); end
    checks++; if (bus.sram_ub_n !== 1'b0 || bus.sram_lb_n !== 1'b0) begin
      errors++; $display("FAIL read_lanes got ub%0b lb%0b exp ub0 lb0", bus.sram_ub_n, bus.sram_lb_n); end
    checks++; if (bus.sram_addr !== 18'(addr >> 1)) begin
      errors++; $display("FAIL read_addr got %h exp %h", bus.sram_addr, 18'(addr >> 1)); end
    checks++; if (bus.vram_vld !== 1'b0) begin errors++; $display("FAIL read_early_vld got %0b exp 0", bus.vram_vld); end
    tick();
    checks++; if (bus.vram_vld !== 1'b1 || bus.vram_data !== exp_px) begin
      errors++; $display("FAIL read_data got vld%0b %h exp vld1 %h", bus.vram_vld, bus.vram_data, exp_px); end
    tick();
    checks++; if (bus.vram_vld !== 1'b0 || bus.vram_data !== exp_px) begin
      errors++; $display("FAIL read_hold got vld%0b %h exp vld0 %h", bus.vram_vld, bus.vram_data, exp_px); end
  endtask

  task automatic test_readback(input int addr);
    tick();
    checks++; if (bus.vram_busy !== 1'b0) begin errors++; $display("FAIL readback_busy got %0b exp 0", bus.vram_busy); end
    bus.vram_rd = 1'b1; bus.vram_addr = 19'(addr);
    tick();
    bus.vram_rd = 1'b0;
    tick();
    checks++; if (bus.vram_vld !== 1'b1 || bus.vram_data !== ref_px[addr]) begin
      errors++; $display("FAIL readback_%0h got vld%0b %h exp vld1 %h", addr, bus.vram_vld, bus.vram_data, ref_px[addr]); end
  endtask

  task automatic test_stream();
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    int         seen;
    logic [7:0] e;
    int         ec;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (bus.vram_vld === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra_vld got data %h at cycle %0d exp none", bus.vram_data, cyc);
        end else begin
          e = exp_q.pop_front(); ec = exp_cyc_q.pop_front(); seen++;
          if (bus.vram_data !== e || cyc != ec) begin
            errors++; $display("FAIL stream_data got %h@%0d exp %h@%0d", bus.vram_data, cyc, e, ec);
          end
        end
      end
      if (i < 8) begin
        bus.vram_rd = 1'b1; bus.vram_addr = 19'(i);
        exp_q.push_back(ref_px[i]); exp_cyc_q.push_back(cyc + 2);
      end else begin
        bus.vram_rd = 1'b0;
      end
    end
    checks++; if (seen != 8) begin errors++; $display("FAIL stream_count got %0d exp 8", seen); end
  endtask

  task automatic test_idle_write();
    tick();
    checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL iw_ready got %0b exp 1", bus.host_ready); end
    bus.host_wr = 1'b1; bus.host_addr = 19'h00003; bus.host_wdata = 8'h3C;
    tick();
    bus.host_wr = 1'b0;
    checks++; if (bus.host_ready !== 1'b0 || bus.vram_busy !== 1'b0) begin
      errors++; $display("FAIL iw_buffered got ready%0b busy%0b exp ready0 busy0", bus.host_ready, bus.vram_busy); end
    tick();
    checks++; if (dbg_state !== 2'd1 || bus.vram_busy !== 1'b1 || bus.host_ready !== 1'b1) begin
      errors++; $display("FAIL iw_setup_state got st%0d busy%0b ready%0b exp st1 busy1 ready1", dbg_state, bus.vram_busy, bus.host_ready); end
    checks++; if ({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe} !== 4'b0110 || bus.sram_addr !== 18'd1) begin
      errors++; $display("FAIL iw_setup_pins got ce/oe/we/oe %b addr %h exp 0110 addr 1",
        {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe}, bus.sram_addr); end
    tick();
    checks++; if (bus.sram_we_n !== 1'b0 || bus.sram_dq_oe !== 1'b1 || bus.sram_dq_o !== 16'h3C3C) begin
      errors++; $display("FAIL iw_pulse got we%0b dq_oe%0b dq %h exp we0 dq_oe1 3c3c", bus.sram_we_n, bus.sram_dq_oe, bus.sram_dq_o); end
    checks++; if (bus.sram_ub_n !== 1'b0 || bus.sram_lb_n !== 1'b1 || bus.sram_ce_n !== 1'b0) begin
      errors++; $display("FAIL iw_lanes got ub%0b lb%0b ce%0b exp ub0 lb1 ce0", bus.sram_ub_n, bus.sram_lb_n, bus.sram_ce_n); end
    tick();
    checks++; if (dbg_state !== 2'd3 || bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b1 || bus.sram_dq_o !== 16'h3C3C
                  || bus.vram_busy !== 1'b1) begin
      errors++; $display("FAIL iw_hold got st%0d we%0b dq_oe%0b dq %h busy%0b exp st3 we1 dq_oe1 3c3c busy1",
        dbg_state, bus.sram_we_n, bus.sram_dq_oe, bus.sram_dq_o, bus.vram_busy); end
    tick();
    checks++; if (bus.vram_busy !== 1'b0 || bus.sram_ce_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL iw_done got busy%0b ce%0b dq_oe%0b exp busy0 ce1 dq_oe0", bus.vram_busy, bus.sram_ce_n, bus.sram_dq_oe); end
    ref_px[3] = 8'h3C;
    test_readback(3);
    test_readback(2);
  endtask

  task automatic test_starvation_refill();
    logic [7:0] exp_q[$];
    int         exp_cyc_q[$];
    int         a1;
    int         busy_cnt;
    logic       exp_busy;
    logic [7:0] e;
    int         ec;
    a1 = -1000; busy_cnt = 0;
    for (int i = 0; i < 55; i++) begin
      tick();
      exp_busy = (cyc >= a1 + 17 && cyc <= a1 + 20) || (cyc >= a1 + 37 && cyc <= a1 + 40);
      checks++; if (bus.vram_busy !== exp_busy) begin
        errors++; $display("FAIL starve_busy cycle %0d got %0b exp %0b", cyc - a1, bus.vram_busy, exp_busy); end
      if (bus.vram_busy === 1'b1) busy_cnt++;
      if (bus.vram_vld === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL starve_extra_vld got data %h at cycle %0d exp none", bus.vram_data, cyc);
        end else begin
          e = exp_q.pop_front(); ec = exp_cyc_q.pop_front();
          if (bus.vram_data !== e || cyc != ec) begin
            errors++; $display("FAIL starve_data got %h@%0d exp %h@%0d", bus.vram_data, cyc, e, ec);
          end
        end
      end
      bus.host_wr = 1'b0;
      if (i == 2) begin
        checks++; if (bus.host_ready !== 1'b1) begin errors++; $display("FAIL starve_ready1 got %0b exp 1", bus.host_ready); end
        bus.host_wr = 1'b1; bus.host_addr = 19'h00041; bus.host_wdata = 8'hC3;
        a1 = cyc;
      end
      if (cyc == a1 + 20) begin
        checks++; if (bus.host_ready !== 1'b1 || dbg_state !== 2'd3) begin
          errors++; $display("FAIL refill_accept got ready%0b st%0d exp ready1 st3", bus.host_ready, dbg_state); end
        bus.host_wr = 1'b1; bus.host_addr = 19'h00042; bus.host_wdata = 8'h96;
      end
      if (cyc == a1 + 21) begin
        checks++; if (bus.host_ready !== 1'b0) begin errors++; $display("FAIL refill_ready got %0b exp 0", bus.host_ready); end
      end
      if (i < 50) begin
        bus.vram_rd = 1'b1; bus.vram_addr = 19'(16 + i % 8);
        if (!exp_busy) begin
          exp_q.push_back(ref_px[16 + i % 8]); exp_cyc_q.push_back(cyc + 2);
        end
      end else begin
        bus.vram_rd = 1'b0;
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL starve_lost_vld got %0d missing exp 0", exp_q.size()); end
    checks++; if (busy_cnt != 8) begin errors++; $display("FAIL starve_busy_total got %0d exp 8", busy_cnt); end
    ref_px[16'h41] = 8'hC3;
    ref_px[16'h42] = 8'h96;
    test_readback(16'h41);
    test_readback(16'h42);
    test_readback(16'h40);
  endtask

  task automatic test_reset_mid_write();
    tick();
    bus.host_wr = 1'b1; bus.host_addr = 19'h00010; bus.host_wdata = 8'hEE;
    tick();
    bus.host_wr = 1'b0;
    tick();
    tick();
    checks++; if (bus.sram_we_n !== 1'b0) begin errors++; $display("FAIL rst_pulse_reached got we%0b exp we0", bus.sram_we_n); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.sram_we_n !== 1'b1 || bus.sram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL rst_abort_pins got we%0b dq_oe%0b exp we1 dq_oe0", bus.sram_we_n, bus.sram_dq_oe); end
    checks++; if (bus.vram_busy !== 1'b0 || bus.host_ready !== 1'b1 || bus.vram_vld !== 1'b0) begin
      errors++; $display("FAIL rst_abort_status got busy%0b ready%0b vld%0b exp busy0 ready1 vld0",
        bus.vram_busy, bus.host_ready, bus.vram_vld); end
    tick();
    rst_n = 1'b1;
    test_readback(16'h10);
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    bus.vram_rd = 1'b0; bus.vram_addr = '0;
    bus.host_wr = 1'b0; bus.host_addr = '0; bus.host_wdata = '0;
    for (int w = 0; w < 256; w++) mem[w] = {8'(w) ^ 8'hC0, 8'(w) ^ 8'h0F};
    mem[1] = 16'h1122;
    mem[2] = 16'hA55A;
    for (int w = 0; w < 256; w++) begin
      ref_px[2*w]   = mem[w][7:0];
      ref_px[2*w+1] = mem[w][15:8];
    end

    test_reset();
    test_read(19'h00005, 8'hA5);
    test_read(19'h00004, 8'h5A);
    test_stream();
    test_idle_write();
    test_starvation_refill();
    test_reset_mid_write();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
